// File: rtl/boot_loader_slave.sv
// ============================================================================
// boot_loader_slave : Wishbone register slave that copies a byte stream into
//                     memory as little-endian 32-bit words.
// Revision 1.0
// ============================================================================
`default_nettype none

module boot_loader_slave #(
  parameter logic [29:0] BASE_ADR = 30'h3000_0000,
  parameter int          MEM_AW   = 16,
  parameter int          SIZE_W   = 16
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [29:0]       ADR_I,
  input  logic [3:0]        SEL_I,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  output logic              ACK_O,
  output logic              ERR_O,
  output logic              RTY_O,
  input  logic              init_done_i,
  output logic              src_start_o,
  output logic [SIZE_W-1:0] src_count_o,
  input  logic [7:0]        src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_adr_o,
  output logic [31:0]       mem_dat_o,
  input  logic              mem_wait_i
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_START   = 3'd2,
    S_COLLECT = 3'd3,
    S_WRITE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         dat_q, dat_d;
  logic [MEM_AW-1:0]   dest_q, dest_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [31:0]         ctrl_q, ctrl_d;
  logic [SIZE_W-1:0]   count_q, count_d;
  logic [SIZE_W-1:0]   rem_q, rem_d;
  logic [MEM_AW-1:0]   adr_q, adr_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         buf_q, buf_d;

  logic        w_access, w_in_win, w_wr, w_busy, w_start;
  logic [1:0]  w_off;
  logic [31:0] w_rdata;
  logic        unused_sel;

  assign unused_sel = ^SEL_I;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    size_d  = size_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    rem_d   = rem_q;
    adr_d   = adr_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    dat_d   = dat_q;

    w_access = CYC_I && STB_I && !ack_q && !err_q;
    w_in_win = (ADR_I[29:2] == BASE_ADR[29:2]);
    w_off    = ADR_I[1:0];
    ack_d    = w_access && w_in_win;
    err_d    = w_access && !w_in_win;
    w_wr     = ack_d && WE_I;
    w_busy   = (state_q == S_START) || (state_q == S_COLLECT) || (state_q == S_WRITE);
    w_start  = w_wr && (w_off == 2'd3) && (DAT_I == 32'd2) && (state_q == S_IDLE);

    case (w_off)
      2'd0: begin
        case (state_q)
          S_INIT:  w_rdata = 32'd0;
          S_IDLE:  w_rdata = 32'd2;
          default: w_rdata = 32'd1;
        endcase
      end
      2'd1:    w_rdata = 32'(dest_q);
      2'd2:    w_rdata = 32'(size_q);
      default: w_rdata = ctrl_q;
    endcase
    if (ack_d) dat_d = w_rdata;

    if (w_wr) begin
      case (w_off)
        2'd1: dest_d = DAT_I[MEM_AW-1:0];
        2'd2: if (!w_busy) size_d = DAT_I[SIZE_W-1:0];
        2'd3: ctrl_d = DAT_I;
        default: ;
      endcase
    end

    // Transfer parameters come from the register values before this cycle's write.
    case (state_q)
      S_INIT: if (init_done_i) state_d = S_IDLE;
      S_IDLE: begin
        if (w_start) begin
          state_d = S_START;
          count_d = size_q;
          rem_d   = size_q;
          adr_d   = dest_q;
        end
      end
      S_START: begin
        lane_d  = 2'd0;
        buf_d   = 32'd0;
        state_d = (rem_q == '0) ? S_IDLE : S_COLLECT;
      end
      S_COLLECT: begin
        if (src_valid_i) begin
          buf_d[{lane_q, 3'b000} +: 8] = src_data_i;
          lane_d = lane_q + 2'd1;
          rem_d  = rem_q - SIZE_W'(1);
          if ((lane_q == 2'd3) || (rem_q == SIZE_W'(1))) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mem_wait_i) begin
          adr_d   = adr_q + MEM_AW'(1);
          buf_d   = 32'd0;
          lane_d  = 2'd0;
          state_d = (rem_q == '0) ? S_IDLE : S_COLLECT;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_INIT;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
      dest_q  <= '0;
      size_q  <= '0;
      ctrl_q  <= 32'd0;
      count_q <= '0;
      rem_q   <= '0;
      adr_q   <= '0;
      lane_q  <= 2'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      dest_q  <= dest_d;
      size_q  <= size_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      adr_q   <= adr_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
    end
  end

  assign DAT_O       = dat_q;
  assign ACK_O       = ack_q;
  assign ERR_O       = err_q;
  assign RTY_O       = 1'b0;
  assign src_start_o = (state_q == S_START);
  assign src_count_o = count_q;
  assign src_ready_o = (state_q == S_COLLECT);
  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_adr_o   = adr_q;
  assign mem_dat_o   = buf_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_slave.sv
// ============================================================================
// tb_boot_loader_slave : scoreboard bench for boot_loader_slave.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_boot_loader_slave;

  localparam logic [29:0] BASE = 30'h3000_0000;

  logic        clk;
  logic        RST_I, CYC_I, STB_I, WE_I;
  logic [29:0] ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_I, DAT_O;
  logic        ACK_O, ERR_O, RTY_O;
  logic        init_done_i, src_start_o, src_valid_i, src_ready_o;
  logic [15:0] src_count_o;
  logic [7:0]  src_data_i;
  logic        mem_we_o, mem_wait_i;
  logic [15:0] mem_adr_o;
  logic [31:0] mem_dat_o;

  boot_loader_slave dut (
    .CLK_I(clk), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .SEL_I(SEL_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O),
    .init_done_i(init_done_i), .src_start_o(src_start_o), .src_count_o(src_count_o),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_wait_i(mem_wait_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  logic [47:0] exp_q[$];
  logic [15:0] start_q[$];
  logic [7:0]  src_q[$];
  logic [7:0]  ld_bytes[$];
  logic        src_en = 1'b1;
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  logic [15:0] hold_adr;
  logic [31:0] hold_dat;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte source: present the head of src_q, pop it when the slave accepts.
  initial begin
    src_valid_i = 1'b0;
    src_data_i  = 8'd0;
    forever begin
      @(negedge clk);
      if (src_en && src_q.size() > 0) begin
        src_valid_i = 1'b1;
        src_data_i  = src_q[0];
        if (src_ready_o) begin
          void'(src_q.pop_front());
          acc_cnt++;
        end
      end else begin
        src_valid_i = 1'b0;
      end
    end
  end

  // Memory and start-pulse monitor with optional stall injection.
  initial begin
    logic [47:0] e;
    mem_wait_i = 1'b0;
    forever begin
      @(negedge clk);
      if (src_start_o) begin
        if (start_q.size() == 0) check_val("stray_start", 32'd1, 32'd0);
        else check_val("src_count", src_count_o, start_q.pop_front());
      end
      if (mem_we_o && wr_cnt == stall_at && stall_left > 0) begin
        mem_wait_i = 1'b1;
        if (stall_left == 5) begin
          hold_adr = mem_adr_o;
          hold_dat = mem_dat_o;
        end else begin
          check_val("stall_adr", mem_adr_o, hold_adr);
          check_val("stall_dat", mem_dat_o, hold_dat);
        end
        check_val("stall_ready", src_ready_o, 32'd0);
        stall_left--;
      end else begin
        mem_wait_i = 1'b0;
        if (mem_we_o) begin
          if (exp_q.size() == 0) check_val("stray_we", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check_val("mem_adr", mem_adr_o, e[47:32]);
            check_val("mem_dat", mem_dat_o, e[31:0]);
          end
          wr_cnt++;
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [29:0] adr, input logic [31:0] wd,
                         input logic exp_err, output logic [31:0] rd);
    @(negedge clk);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd; SEL_I = 4'hF;
    @(posedge clk); #1;
    check_val(exp_err ? "err_pulse" : "ack_pulse", {ERR_O, ACK_O}, exp_err ? 32'd2 : 32'd1);
    rd = DAT_O;
    @(posedge clk); #1;
    check_val("ack_1cyc", {ERR_O, ACK_O}, 32'd0);
    @(negedge clk);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, BASE + 30'(off), d, 1'b0, rd);
  endtask

  task automatic wb_read(input logic [1:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    wb_xfer(1'b0, BASE + 30'(off), 32'd0, 1'b0, rd);
    check_val(tag, rd, exp);
  endtask

  // Queue expected words and bytes for ld_bytes, then issue the command.
  task automatic start_load(input logic [15:0] dest, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i += 4) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (i + k < n) w[8*k +: 8] = ld_bytes[i + k];
      exp_q.push_back({dest + 16'(i / 4), w});
    end
    for (int i = 0; i < n; i++) src_q.push_back(ld_bytes[i]);
    start_q.push_back(16'(n));
    wb_write(2'd1, 32'(dest));
    wb_write(2'd2, 32'(n));
    wb_write(2'd3, 32'd2);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val("drain_left", exp_q.size() + start_q.size(), 32'd0);
  endtask

  initial begin
    int w0, a0, c;
    logic [31:0] rd;
    CYC_I = 0; STB_I = 0; WE_I = 0; ADR_I = 0; SEL_I = 0; DAT_I = 0;
    init_done_i = 1'b0;
    RST_I = 1'b1;
    #1 RST_I = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ack", {ERR_O, ACK_O, RTY_O}, 32'd0);
    check_val("rst_we", {mem_we_o, src_ready_o, src_start_o}, 32'd0);
    RST_I = 1'b1;

    wb_read(2'd0, 32'd0, "status_init");
    wb_read(2'd1, 32'd0, "dest_rst");
    wb_read(2'd2, 32'd0, "size_rst");
    wb_read(2'd3, 32'd0, "ctrl_rst");
    init_done_i = 1'b1;
    repeat (2) @(negedge clk);
    wb_read(2'd0, 32'd2, "status_idle");

    // Full boot image
    ld_bytes.delete();
    for (int i = 0; i < 2048; i++) ld_bytes.push_back(8'(i));
    w0 = wr_cnt;
    start_load(16'h0100, 2048);
    wb_read(2'd0, 32'd1, "status_busy");
    drain(6000);
    check_val("boot_writes", wr_cnt - w0, 32'd512);
    wb_read(2'd0, 32'd2, "status_done");

    // Partial last word
    ld_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    w0 = wr_cnt;
    start_load(16'h0400, 6);
    drain(200);
    check_val("six_writes", wr_cnt - w0, 32'd2);
    wb_read(2'd0, 32'd2, "status_six");

    // Zero-length command
    ld_bytes.delete();
    w0 = wr_cnt;
    start_load(16'h0500, 0);
    drain(50);
    repeat (3) @(negedge clk);
    check_val("zero_writes", wr_cnt - w0, 32'd0);
    wb_read(2'd0, 32'd2, "status_zero");

    // Stall on the third write
    ld_bytes.delete();
    for (int i = 0; i < 20; i++) ld_bytes.push_back(8'($urandom_range(0, 255)));
    stall_at = wr_cnt + 2;
    stall_left = 5;
    start_load(16'h0600, 20);
    drain(500);
    check_val("stall_used", stall_left, 32'd0);
    wb_read(2'd0, 32'd2, "status_stall");

    // Commands while busy, out-of-window access
    src_en = 1'b0;
    ld_bytes.delete();
    for (int i = 0; i < 40; i++) ld_bytes.push_back(8'(8'h40 + i));
    w0 = wr_cnt;
    start_load(16'h0900, 40);
    wb_read(2'd0, 32'd1, "status_busy2");
    wb_write(2'd2, 32'd16);
    wb_write(2'd3, 32'd2);
    wb_read(2'd2, 32'd40, "size_keep");
    wb_read(2'd3, 32'd2, "ctrl_rb");
    wb_xfer(1'b0, BASE + 30'd4, 32'd0, 1'b1, rd);
    src_en = 1'b1;
    drain(500);
    check_val("busy_writes", wr_cnt - w0, 32'd10);
    wb_read(2'd0, 32'd2, "status_busy_done");

    // Reset in the middle of a transfer
    ld_bytes.delete();
    for (int i = 0; i < 64; i++) ld_bytes.push_back(8'(i * 3));
    start_load(16'h0A00, 64);
    a0 = acc_cnt;
    c = 0;
    while (acc_cnt - a0 < 37 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check_val("bytes_before_rst", (acc_cnt - a0 >= 37) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #2;
    RST_I = 1'b0;
    init_done_i = 1'b0;
    #1;
    check_val("arst_ctl", {mem_we_o, src_ready_o, src_start_o, ACK_O, ERR_O}, 32'd0);
    check_val("arst_adr", mem_adr_o, 32'd0);
    check_val("arst_dat", mem_dat_o, 32'd0);
    check_val("arst_cnt", src_count_o, 32'd0);
    check_val("arst_dato", DAT_O, 32'd0);
    exp_q.delete();
    src_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
    RST_I = 1'b1;
    wb_read(2'd0, 32'd0, "status_post_rst");
    repeat (10) @(negedge clk);
    wb_read(2'd0, 32'd0, "status_wait_init");
    init_done_i = 1'b1;
    repeat (2) @(negedge clk);
    wb_read(2'd0, 32'd2, "status_reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/boot_loader_slave.md
Name: boot_loader_slave

Overview:
- Wishbone classic slave that sits behind the boot-master window and serves STATUS/DEST/SIZE/CONTROL registers.
- On a CONTROL=2 command it pulls SIZE bytes from a byte-stream storage source.
- It packs the bytes into little-endian 32-bit words and writes them through a simple memory write port starting at DEST.
- STATUS reports INIT (0), BUSY (1) or IDLE (2), which is the value the boot master polls for.

Parameters:
- BASE_ADR, 30'h3000_0000, word address of register 0; window is BASE_ADR..BASE_ADR+3.
- MEM_AW, 16, width of the memory word address.
- SIZE_W, 16, implemented bits of SIZE; upper bits read as 0.

Ports:
- CLK_I  in  1  clock, all logic on rising edge.
- RST_I  in  1  asynchronous, active-low reset (0 = reset).
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  Wishbone write enable.
- ADR_I  in  30  Wishbone word address [31:2].
- SEL_I  in  4  byte selects; ignored, full-word access only.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, valid with ACK_O.
- ACK_O  out  1  access acknowledge.
- ERR_O  out  1  error acknowledge, out-of-window access.
- RTY_O  out  1  tied 0.
- init_done_i  in  1  level from storage device: initialised and ready.
- src_start_o  out  1  one-cycle pulse that starts a source read.
- src_count_o  out  SIZE_W  byte count for the source, valid from src_start_o until done.
- src_data_i  in  8  source byte.
- src_valid_i  in  1  byte valid.
- src_ready_o  out  1  byte accepted when src_valid_i && src_ready_o.
- mem_we_o  out  1  memory word write request.
- mem_adr_o  out  MEM_AW  memory word address.
- mem_dat_o  out  32  memory write data.
- mem_wait_i  in  1  memory stall; hold write while high.

Behaviour:
- Reset values (RST_I=0, asynchronous): all outputs 0, DEST=0, SIZE=0, CONTROL=0, FSM state S_INIT, byte/word counters 0.
- Wishbone access and acknowledge:
  - Access = CYC_I && STB_I && !ACK_O && !ERR_O.
  - In-window access (ADR_I[29:2]==BASE_ADR[29:2]) gets ACK_O high for exactly 1 cycle, in the cycle after the access is sampled. DAT_O is registered in the same edge.
  - Out-of-window access gets ERR_O with the same timing; no register effect.
  - Between acknowledges, ACK_O and ERR_O are 0 and DAT_O holds its last value.
- Register map (offset = ADR_I[1:0]):
  - 0 STATUS, RO: 0 in S_INIT, 2 in S_IDLE, 1 in any other state. Writes are acked and ignored.
  - 1 DEST, RW: start word address, lower MEM_AW bits stored.
  - 2 SIZE, RW: byte count, lower SIZE_W bits stored. Writes while BUSY are acked and ignored.
  - 3 CONTROL, RW: stores the written value. A write of exactly 2 while in S_IDLE starts a load; any other value, or any write outside S_IDLE, only updates the readback.
- FSM:
  - S_INIT -> S_IDLE when init_done_i==1.
  - S_IDLE -> S_START on a start command. S_START latches SIZE into src_count_o and DEST into mem_adr_o.
  - S_START: src_start_o=1 for one cycle. If SIZE==0 go to S_IDLE, else go to S_COLLECT.
  - S_COLLECT: src_ready_o=1. Each accepted byte goes into lane k = bytes_taken mod 4 (lane 0 = bits[7:0]). After the 4th lane, or after the final byte, go to S_WRITE with unfilled lanes = 0.
  - S_WRITE: mem_we_o=1 with stable mem_adr_o/mem_dat_o while mem_wait_i==1. On the first cycle with mem_wait_i==0 the write completes:
    - mem_adr_o increments by 1 (wraps modulo 2^MEM_AW) and the word buffer clears.
    - If remaining bytes == 0, go to S_IDLE; else return to S_COLLECT.
  - src_ready_o=0 in all states other than S_COLLECT.
- Word count = ceil(SIZE/4). SIZE=2048 gives 512 writes. A new STATUS read returns 2 no earlier than the cycle after the last write completes.
- init_done_i dropping after S_INIT is ignored.
- Simultaneous register write and FSM transition: the FSM uses the pre-write register values. A CONTROL=2 write is the only start trigger.
- Reset mid-transfer aborts immediately: all outputs 0, state S_INIT. A partially collected word is discarded.

Test Plan:
- Reset with init_done_i=0, read STATUS -> 0. Raise init_done_i, read STATUS -> 2. Every access gets a 1-cycle ACK_O one cycle after STB_I.
- Boot sequence: write SIZE=2048, CONTROL=2, DEST=0x0100 -> one src_start_o pulse with src_count_o=2048, STATUS reads 1. Feed bytes 0..2047 (mod 256) -> 512 writes at 0x0100..0x02FF, first mem_dat_o=32'h03020100, then STATUS=2.
- SIZE=6, bytes AA..FF -> two writes: 32'hDDCCBBAA, then 32'h0000FFEE. SIZE=0 -> src_start_o pulse, no writes, STATUS returns to 2.
- Hold mem_wait_i=1 for 5 cycles on the 3rd write -> mem_we_o/mem_adr_o/mem_dat_o stable, src_ready_o=0, no byte lost.
- CONTROL=2 and SIZE=16 written while BUSY -> acked, no restart, transfer count unchanged. Read of ADR_I=BASE_ADR+4 -> ERR_O pulse, ACK_O=0.
- RST_I=0 mid-transfer after 37 bytes -> outputs 0 asynchronously. After release, STATUS=0 until init_done_i is high, no stray mem_we_o.
